// File: rtl/id_ex_hazard_stage.sv
// rtl/id_ex_hazard_stage.sv - ID/EX pipeline register with load-use interlock and stall counter
// Bubbles on flush or stall; control bits of an invalid ID slot are forced to 0.
module id_ex_hazard_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic              signal_sw,
  input  logic              signal_lw,
  input  logic              signal_regwrite,
  input  logic              signal_memtoreg,
  input  logic              signal_branch,
  input  logic              signal_alusrc,
  input  logic              signal_regdst,
  input  logic              signal_uses_rt,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] sign_ext_imm,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_sw,
  output logic              ex_lw,
  output logic              ex_regwrite,
  output logic              ex_memtoreg,
  output logic              ex_branch,
  output logic              ex_alusrc,
  output logic              ex_regdst,
  output logic [3:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_read_data1,
  output logic [DATA_W-1:0] ex_read_data2,
  output logic [DATA_W-1:0] ex_sign_ext_imm,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic bubble;

  // $zero never needs an interlock; a flush kills the dependent instruction anyway.
  assign stall = ex_valid & ex_lw & id_valid & (ex_rt != 5'd0) &
                 ((ex_rt == rs) | (signal_uses_rt & (ex_rt == rt))) & ~flush;
  assign bubble = flush | stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid        <= 1'b0;
      ex_sw           <= 1'b0;
      ex_lw           <= 1'b0;
      ex_regwrite     <= 1'b0;
      ex_memtoreg     <= 1'b0;
      ex_branch       <= 1'b0;
      ex_alusrc       <= 1'b0;
      ex_regdst       <= 1'b0;
      ex_alu_op       <= '0;
      ex_read_data1   <= '0;
      ex_read_data2   <= '0;
      ex_sign_ext_imm <= '0;
      ex_pc_plus4     <= '0;
      ex_rs           <= '0;
      ex_rt           <= '0;
      ex_rd           <= '0;
    end else if (bubble) begin
      ex_valid        <= 1'b0;
      ex_sw           <= 1'b0;
      ex_lw           <= 1'b0;
      ex_regwrite     <= 1'b0;
      ex_memtoreg     <= 1'b0;
      ex_branch       <= 1'b0;
      ex_alusrc       <= 1'b0;
      ex_regdst       <= 1'b0;
      ex_alu_op       <= '0;
      ex_read_data1   <= '0;
      ex_read_data2   <= '0;
      ex_sign_ext_imm <= '0;
      ex_pc_plus4     <= '0;
      ex_rs           <= '0;
      ex_rt           <= '0;
      ex_rd           <= '0;
    end else begin
      ex_valid        <= id_valid;
      ex_sw           <= id_valid & signal_sw;
      ex_lw           <= id_valid & signal_lw;
      ex_regwrite     <= id_valid & signal_regwrite;
      ex_memtoreg     <= id_valid & signal_memtoreg;
      ex_branch       <= id_valid & signal_branch;
      ex_alusrc       <= id_valid & signal_alusrc;
      ex_regdst       <= id_valid & signal_regdst;
      ex_alu_op       <= alu_op;
      ex_read_data1   <= read_data1;
      ex_read_data2   <= read_data2;
      ex_sign_ext_imm <= sign_ext_imm;
      ex_pc_plus4     <= pc_plus4;
      ex_rs           <= rs;
      ex_rt           <= rt;
      ex_rd           <= rd;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: doc/id_ex_hazard_stage.md
# id_ex_hazard_stage

ID/EX pipeline register bank for the MIPS32 core with built-in load-use hazard detection. It captures decoded control and operand fields from the ID stage every clock and presents them to EX. It detects a load-use dependency against the instruction currently in EX and asserts `stall` to freeze PC and IF/ID. It inserts a bubble into EX on stall or flush, and keeps a saturating stall counter for performance debug.

## Interface
Parameters:
- `DATA_W`, 32: operand and PC width.
- `CNT_W`, 16: stall counter width.

Ports:
- `clock`  in  1: single rising-edge clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `id_valid`  in  1: ID holds a real instruction.
- `signal_sw`, `signal_lw`, `signal_regwrite`, `signal_memtoreg`, `signal_branch`, `signal_alusrc`, `signal_regdst`  in  1 each: decoded control from ID.
- `signal_uses_rt`  in  1: ID instruction reads `rt` as a source (R-type, sw, beq).
- `alu_op`  in  4: ALU operation code.
- `read_data1`, `read_data2`, `sign_ext_imm`, `pc_plus4`  in  DATA_W each: ID operands.
- `rs`, `rt`, `rd`  in  5 each: ID register specifiers.
- `flush`  in  1: branch taken resolved in EX; kill the ID instruction.
- `ex_*`  out: registered copies of every control, operand and specifier input above, with the `ex_` prefix. `ex_uses_rt` is not exported.
- `ex_valid`  out  1: EX holds a real instruction.
- `stall`  out  1: combinational; hold PC and IF/ID this cycle.
- `stall_count`  out  CNT_W: saturating count of stall cycles.

## Operation
- Hazard condition, combinational: `stall` = `ex_valid & ex_lw & id_valid & (ex_rt != 0) & ((ex_rt == rs) | (signal_uses_rt & ex_rt == rt)) & ~flush`.
- Register update on each rising edge, in priority order:
  - `flush`=1: insert a bubble.
  - `stall`=1: insert a bubble.
  - Otherwise: capture all ID inputs. `ex_valid` ← `id_valid`.
- Bubble:
  - `ex_valid`=0.
  - All seven control outputs and `ex_alu_op` = 0.
  - Operand, PC and specifier outputs = 0.
- Control outputs are additionally gated: when `id_valid`=0, captured control bits are forced to 0, so an invalid slot can never write memory or registers.
- `stall_count`:
  - Increments by 1 on every edge where `stall`=1.
  - Saturates at 2^CNT_W−1.
  - Never wraps.
  - Cleared only by reset.
- A load with `ex_rt`=0 never stalls. Register $zero needs no interlock.
- Back-to-back lw → lw → use: each dependency is evaluated independently against EX. At most one stall cycle per load-use pair.

## Timing
- Latency: ID inputs appear on `ex_*` exactly 1 cycle later.
- `stall` has zero latency: it is a function of current ID inputs and current `ex_*` registers.
  - After one stall cycle the bubble occupies EX, so `stall` deasserts the next cycle. The held instruction then captures normally.
  - Stall never lasts more than 1 consecutive cycle for the same ID instruction.
- `flush` and hazard in the same cycle: flush wins. `stall`=0, a bubble enters EX, and `stall_count` does not increment.
- Reset:
  - Asserting `reset_n`=0 at any time, including mid-stall, immediately clears all `ex_*` outputs, `ex_valid` and `stall_count` to 0.
  - `stall` reads 0 while in reset, because `ex_valid`=0.
- Reset release is synchronous to `clock`. The first capture occurs on the first rising edge with `reset_n`=1.

## Test plan
- **Reset:** hold `reset_n`=0 with random inputs and toggle `clock`; all outputs must read 0. Deassert `reset_n`, drive `id_valid`=1, `signal_sw`=1, `rs`=3; one edge later `ex_sw`=1, `ex_rs`=3, `ex_valid`=1.
- **Load-use:**
  - Drive lw with `rt`=5, then `add` with `rs`=5.
  - Required: `stall`=1 for exactly 1 cycle, and EX shows a bubble (`ex_valid`=0, `ex_regwrite`=0).
  - Required next cycle: the `add` is captured, and `stall_count`=1.
- **$zero and rt-unused:**
  - Drive lw `rt`=0 followed by a use of `rs`=0; `stall` must be 0.
  - Drive lw `rt`=7 followed by an addi with `rt`=7 and `signal_uses_rt`=0; `stall` must be 0.
- **Flush priority:** create a load-use hazard and assert `flush` in the same cycle. Required: `stall`=0, bubble in EX, `stall_count` unchanged.
- **Saturation:** with `CNT_W`=2, force 5 separate load-use stalls. `stall_count` must read 3 and hold.
- **Mid-stall reset:** pull `reset_n` low asynchronously while `stall`=1. `stall` and all `ex_*` outputs must drop to 0 before the next clock edge.
